keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner: input-side counterpart of the multiplexed 7-seg display path.

---
 rtl/keypad_scan_if.sv | 21 ++
 rtl/keypad_scan.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad row/column lines, key outputs and digit history for keypad_scan.
// master = keypad/consumer side, slave = scanner side.
interface keypad_scan_if;
  logic [3:0]  ROW;
  logic        clr;
  logic [3:0]  COL;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] Hexs;

  modport master (
    output ROW, clr,
    input  COL, key_code, key_valid, key_held, Hexs
  );

  modport slave (
    input  ROW, clr,
    output COL, key_code, key_valid, key_held, Hexs
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with frame-level debounce and 16-bit digit history.
// Optional auto-repeat while a key stays down is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 32
) (
  input  logic         clk,
  input  logic         RST,
  keypad_scan_if.slave kp
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  logic [3:0]               row_meta_q, row_sync_q;
  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic [1:0]               hit_cnt_q, hit_cnt_d;
  logic [3:0]               hit_code_q, hit_code_d;
  state_t                   state_q, state_d;
  logic [3:0]               cand_q, cand_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [3:0]               key_code_q, key_code_d;
  logic                     key_valid_q, key_valid_d;
  logic [15:0]              hexs_q, hexs_d;

  logic       tick, frame_end, frame_key, col_multi, accept;
  logic [3:0] pressed, acc_code;
  logic [1:0] acc_cnt, row_first;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
`endif

  // Scan timing and per-frame hit accumulation; hit_cnt saturates at 2 meaning "several keys".
  always_comb begin
    tick       = &div_q;
    div_d      = div_q + SCAN_DIV_BITS'(1);
    col_idx_d  = tick ? col_idx_q + 2'd1 : col_idx_q;
    pressed    = ~row_sync_q;
    col_multi  = (pressed & (pressed - 4'd1)) != 4'd0;
    row_first  = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
    acc_cnt    = hit_cnt_q;
    acc_code   = hit_code_q;
    if (tick && pressed != 4'd0) begin
      if (hit_cnt_q == 2'd0 && !col_multi) begin
        acc_cnt  = 2'd1;
        acc_code = {row_first, col_idx_q};
      end else begin
        acc_cnt  = 2'd2;
      end
    end
    frame_end  = tick && (col_idx_q == 2'd3);
    frame_key  = frame_end && (acc_cnt == 2'd1);
    hit_cnt_d  = frame_end ? 2'd0 : acc_cnt;
    hit_code_d = acc_code;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + REP_W'(1);
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_key) begin
            cand_d = acc_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = PRESSED;
              accept  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!frame_key) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (acc_code != cand_q) begin
            cand_d  = acc_code;
            cnt_d   = CNT_W'(1);
          end else if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
            state_d = PRESSED;
            accept  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        PRESSED: begin
          // In PRESSED, cnt counts consecutive empty frames toward release.
          if (frame_key) begin
            cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (acc_code == cand_q) begin
              if (rep_inc == REP_W'(REPEAT_FRAMES)) begin
                accept = 1'b1;
                rep_d  = '0;
              end else begin
                rep_d  = rep_inc;
              end
            end
`endif
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = '0;
`endif
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef KEYPAD_AUTOREPEAT_EN
      if (state_q != PRESSED && state_d == PRESSED) rep_d = '0;
`endif
    end
  end

  // clr has priority over a coinciding accept for the history word only.
  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    hexs_d      = kp.clr ? 16'h0000 : (accept ? {hexs_q[11:0], cand_d} : hexs_q);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      hit_cnt_q   <= 2'd0;
      hit_code_q  <= 4'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      hexs_q      <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_meta_q  <= kp.ROW;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_code_q  <= hit_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      hexs_q      <= hexs_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign kp.COL       = ~(4'b0001 << col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == PRESSED);
  assign kp.Hexs      = hexs_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized frame-level keypad stimulus; a run-length reference model queues
// expected key events and a monitor checks every key_valid pulse against the queue.
module tb_keypad_scan;
  localparam int SDB   = 2;
  localparam int DS    = 2;
  localparam int RF    = 3;
  localparam int TICK  = 1 << SDB;
  localparam int FRAME = 4 * TICK;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic started = 1'b0;

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV_BITS (SDB),
    .DEBOUNCE_SCANS(DS),
    .REPEAT_FRAMES (RF)
  ) dut (
    .clk(clk),
    .RST(RST),
    .kp (kp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] hexs;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] keys;
  logic [3:0]  row_drv;
  logic [3:0]  col_exp;
  int          cyc;
  int          n_cmp = 0;
  int          n_fail = 0;

  int          fr, m_run_key, m_run_len, m_none_len, m_rep;
  logic        m_held;
  logic [15:0] m_hexs;

  // Physical keypad: a row reads low when a pressed key in it sits on the driven column.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.COL[c]) row_drv[r] = 1'b0;
  end
  assign kp.ROW = row_drv;

  always @(posedge clk or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    fr = 0; m_run_key = 0; m_run_len = 0; m_none_len = 0; m_rep = 0;
    m_held = 1'b0; m_hexs = 16'h0000;
  endtask

  // One scan frame with a fixed key set; the model decides from run lengths of frame results.
  task automatic applyStimulus(input logic [15:0] k, input bit do_clr);
    int  r;
    bit  acc;
    checkOutput("key_held", kp.key_held, m_held);
    checkOutput("Hexs", kp.Hexs, m_hexs);
    keys = k;
    fr++;
    r = -1;
    if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) r = i;
    acc = 1'b0;
    if (!m_held) begin
      if (r < 0) m_run_len = 0;
      else if (m_run_len > 0 && r == m_run_key) m_run_len++;
      else begin m_run_key = r; m_run_len = 1; end
      if (m_run_len == DS) begin
        acc = 1'b1; m_held = 1'b1; m_run_len = 0; m_none_len = 0; m_rep = 0;
      end
    end else if (r < 0) begin
      m_rep = 0;
      m_none_len++;
      if (m_none_len == DS) begin m_held = 1'b0; m_none_len = 0; end
    end else begin
      m_none_len = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (r == m_run_key) begin
        m_rep++;
        if (m_rep == RF) begin acc = 1'b1; m_rep = 0; end
      end
`endif
    end
    if (acc) begin
      m_hexs = do_clr ? 16'h0000 : {m_hexs[11:0], m_run_key[3:0]};
      exp_q.push_back('{code: m_run_key[3:0], hexs: m_hexs, at: fr * FRAME});
    end else if (do_clr) begin
      m_hexs = 16'h0000;
    end
    repeat (FRAME - 1) @(negedge clk);
    if (do_clr) kp.clr = 1'b1;
    @(negedge clk);
    kp.clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!RST && started) begin
      col_exp = ~(4'b0001 << ((cyc / TICK) % 4));
      checkOutput("COL", kp.COL, col_exp);
      if (kp.key_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("key_valid", kp.key_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("key_code", kp.key_code, mon_e.code);
          checkOutput("Hexs at key_valid", kp.Hexs, mon_e.hexs);
          checkOutput("key_valid cycle", cyc, mon_e.at);
        end
      end
    end
  end

  initial begin
    logic [15:0] cur;
    int          p, a, b;
    logic [15:0] seq [4];
    seq[0] = 16'h0002; seq[1] = 16'h0004; seq[2] = 16'h0008; seq[3] = 16'h0400;
    kp.clr = 1'b0;
    keys   = 16'h0000;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset COL", kp.COL, 4'b1110);
    checkOutput("reset Hexs", kp.Hexs, 16'h0000);
    checkOutput("reset key_valid", kp.key_valid, 1'b0);
    checkOutput("reset key_held", kp.key_held, 1'b0);
    checkOutput("reset key_code", kp.key_code, 4'h0);
    RST = 1'b0;
    started = 1'b1;

    repeat (3) applyStimulus(16'h0040, 1'b0);
    repeat (3) applyStimulus(16'h0000, 1'b0);

    for (int i = 0; i < 4; i++) begin
      repeat (2) applyStimulus(seq[i], 1'b0);
      repeat (2) applyStimulus(16'h0000, 1'b0);
    end
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b0);

    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 16'h0020 : 16'h0000, 1'b0);
    repeat (2) applyStimulus(16'h0020, 1'b0);
    repeat (3) applyStimulus(16'h0000, 1'b0);

    repeat (4) applyStimulus(16'h8001, 1'b0);
    repeat (2) applyStimulus(16'h0000, 1'b0);

    applyStimulus(16'h0080, 1'b0);
    applyStimulus(16'h0080, 1'b1);
    repeat (3) applyStimulus(16'h0000, 1'b0);

    repeat (11) applyStimulus(16'h0200, 1'b0);
    repeat (3) applyStimulus(16'h0000, 1'b0);

    cur = 16'h0000;
    for (int i = 0; i < 80; i++) begin
      p = $urandom_range(0, 9);
      if (p < 3) cur = 16'h0000;
      else if (p == 3) begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        cur = 16'h0000;
        cur[a] = 1'b1;
        cur[b] = 1'b1;
      end else if (p < 6) begin
        cur = 16'h0000;
        cur[$urandom_range(0, 15)] = 1'b1;
      end
      applyStimulus(cur, $urandom_range(0, 15) == 0);
    end
    repeat (3) applyStimulus(16'h0000, 1'b0);

    applyStimulus(16'h1000, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("pending before reset", exp_q.size(), 0);
    RST = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset key_valid", kp.key_valid, 1'b0);
    checkOutput("mid-reset key_held", kp.key_held, 1'b0);
    checkOutput("mid-reset COL", kp.COL, 4'b1110);
    checkOutput("mid-reset Hexs", kp.Hexs, 16'h0000);
    checkOutput("mid-reset key_code", kp.key_code, 4'h0);
    repeat (2) @(negedge clk);
    keys = 16'h0000;
    modelReset();
    RST = 1'b0;
    repeat (2) applyStimulus(16'h0000, 1'b0);
    repeat (3) applyStimulus(16'h0008, 1'b0);
    repeat (3) applyStimulus(16'h0000, 1'b0);

    repeat (FRAME) @(negedge clk);
    checkOutput("pending key_valid", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
